// File: rtl/module_decode_ctrl_pkg.sv
// Shared decode definitions for the RV32I ID-stage control unit: opcodes,
// format/result/ALU encodings, the EX control bundle and the halt FSM states.
package pkg_decode;

  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_REG      = 7'b0110011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_PRIV     = 3'b000;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10,
    RES_IMM  = 2'b11
  } result_src_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } fsm_state_e;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    result_src_e result_src;
    logic        alu_src_a;
    logic        alu_src_b;
    alu_ctrl_e   alu_ctrl;
    logic        branch;
    logic        jump;
    logic        jalr;
    logic [2:0]  funct3;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = '0;

  // Register and immediate ALU ops share funct3; only the register form may subtract.
  function automatic alu_ctrl_e alu_from_funct(input logic [2:0] funct3,
                                               input logic       f7b5,
                                               input logic       is_reg);
    case (funct3)
      3'b000:  return (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic alu_ctrl_e alu_for_branch(input logic [2:0] funct3);
    case (funct3[2:1])
      2'b10:   return ALU_SLT;
      2'b11:   return ALU_SLTU;
      default: return ALU_SUB;
    endcase
  endfunction

endpackage

// File: rtl/module_decode_ctrl_main_decoder.sv
// Purely combinational RV32I main decoder: instruction word to immediate
// format, EX control bundle, illegal flag and ECALL/EBREAK detect.
module module_main_decoder
  import pkg_decode::*;
(
  input  logic [31:0]  instr,
  output imm_src_e     imm_src,
  output ctrl_bundle_t ctrl,
  output logic         illegal,
  output logic         is_halt
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7b5;
  logic       unused_bits;

  assign opcode      = instr[6:0];
  assign funct3      = instr[14:12];
  assign f7b5        = instr[30];
  assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

  always_comb begin
    imm_src     = IMM_I;
    ctrl        = CTRL_BUBBLE;
    ctrl.funct3 = funct3;
    illegal     = 1'b0;
    is_halt     = 1'b0;
    case (opcode)
      OP_REG: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_ctrl  = alu_from_funct(funct3, f7b5, 1'b1);
      end
      OP_IMM: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_b = 1'b1;
        ctrl.alu_ctrl  = alu_from_funct(funct3, f7b5, 1'b0);
      end
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src_b  = 1'b1;
        ctrl.result_src = RES_LOAD;
        ctrl.alu_ctrl   = ALU_ADD;
      end
      OP_STORE: begin
        imm_src        = IMM_S;
        ctrl.mem_write = 1'b1;
        ctrl.alu_src_b = 1'b1;
        ctrl.alu_ctrl  = ALU_ADD;
      end
      OP_BRANCH: begin
        imm_src       = IMM_B;
        ctrl.branch   = 1'b1;
        ctrl.alu_ctrl = alu_for_branch(funct3);
      end
      OP_JAL: begin
        imm_src         = IMM_J;
        ctrl.jump       = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_PC4;
      end
      OP_JALR: begin
        ctrl.jump       = 1'b1;
        ctrl.jalr       = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_PC4;
        ctrl.alu_src_b  = 1'b1;
        ctrl.alu_ctrl   = ALU_ADD;
      end
      OP_LUI: begin
        imm_src         = IMM_U;
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_IMM;
      end
      OP_AUIPC: begin
        imm_src        = IMM_U;
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 1'b1;
        ctrl.alu_ctrl  = ALU_ADD;
      end
      OP_MISC_MEM: begin
      end
      OP_SYSTEM: begin
        // Only ECALL/EBREAK are supported; CSR accesses trap as illegal.
        if (funct3 == F3_PRIV) is_halt = 1'b1;
        else                   illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/module_decode_ctrl.sv
// ID-stage control: decode, ID/EX control register with stall/flush,
// sticky illegal-instruction capture and the ECALL/EBREAK drain-and-halt FSM.
module module_decode_ctrl
  import pkg_decode::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_d_i,
  input  logic        valid_d_i,
  input  logic        stall_e_i,
  input  logic        flush_e_i,
  output logic [2:0]  imm_src_d_o,
  output logic        valid_e_o,
  output logic        reg_write_e_o,
  output logic        mem_write_e_o,
  output logic [1:0]  result_src_e_o,
  output logic        alu_src_a_e_o,
  output logic        alu_src_b_e_o,
  output logic [3:0]  alu_ctrl_e_o,
  output logic        branch_e_o,
  output logic        jump_e_o,
  output logic        jalr_e_o,
  output logic [2:0]  funct3_e_o,
  output logic        stall_fd_o,
  output logic        halted_o,
  output logic        illegal_o,
  output logic [31:0] illegal_instr_o
);

  imm_src_e     imm_src_p0;
  ctrl_bundle_t ctrl_p0;
  logic         illegal_p0;
  logic         is_halt_p0;

  ctrl_bundle_t ctrl_p1;
  logic         vld_p1;

  fsm_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        load_en;
  logic        issue_en;
  logic        accept_p0;
  logic        illegal_q;
  logic [31:0] illegal_instr_q;

  module_main_decoder u_main_decoder (
    .instr   (instr_d_i),
    .imm_src (imm_src_p0),
    .ctrl    (ctrl_p0),
    .illegal (illegal_p0),
    .is_halt (is_halt_p0)
  );

  assign imm_src_d_o = imm_src_p0;
  assign load_en     = ~flush_e_i & ~stall_e_i;
  assign accept_p0   = valid_d_i & ~illegal_p0 & issue_en;

  // ---- ID -> EX boundary ----
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_e_i) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= CTRL_BUBBLE;
    end else if (load_en) begin
      vld_p1  <= accept_p0;
      ctrl_p1 <= accept_p0 ? ctrl_p0 : CTRL_BUBBLE;
    end
  end

  assign valid_e_o      = vld_p1;
  assign reg_write_e_o  = ctrl_p1.reg_write;
  assign mem_write_e_o  = ctrl_p1.mem_write;
  assign result_src_e_o = ctrl_p1.result_src;
  assign alu_src_a_e_o  = ctrl_p1.alu_src_a;
  assign alu_src_b_e_o  = ctrl_p1.alu_src_b;
  assign alu_ctrl_e_o   = ctrl_p1.alu_ctrl;
  assign branch_e_o     = ctrl_p1.branch;
  assign jump_e_o       = ctrl_p1.jump;
  assign jalr_e_o       = ctrl_p1.jalr;
  assign funct3_e_o     = ctrl_p1.funct3;

  // Only the first offending word is kept so software sees the root cause.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      illegal_q       <= 1'b0;
      illegal_instr_q <= '0;
    end else if (load_en && valid_d_i && illegal_p0 && !illegal_q) begin
      illegal_q       <= 1'b1;
      illegal_instr_q <= instr_d_i;
    end
  end

  assign illegal_o       = illegal_q;
  assign illegal_instr_o = illegal_instr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The halting instruction must actually enter EX, so a stalled or flushed
  // slot leaves the FSM in RUN; once draining, flushes no longer matter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (load_en && valid_d_i && is_halt_p0) begin
          state_d = ST_DRAIN;
          cnt_d   = CNT_W'(DRAIN_CYCLES);
        end
      end
      ST_DRAIN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_HALTED;
      end
      ST_HALTED: begin
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    issue_en   = (state_q == ST_RUN);
    stall_fd_o = (state_q != ST_RUN);
    halted_o   = (state_q == ST_HALTED);
  end

endmodule

// File: tb/tb_module_decode_ctrl.sv
// Directed bench for module_decode_ctrl: a vector table for decode and the
// ID/EX register, plus hand sequences for illegal capture and the halt FSM.
module tb_module_decode_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        valid, stall, flush;
  logic [2:0]  imm_src;
  logic        valid_e, reg_write_e, mem_write_e, alu_src_a_e, alu_src_b_e;
  logic [1:0]  result_src_e;
  logic [3:0]  alu_ctrl_e;
  logic        branch_e, jump_e, jalr_e;
  logic [2:0]  funct3_e;
  logic        stall_fd, halted, illegal;
  logic [31:0] illegal_instr;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  module_decode_ctrl #(.DRAIN_CYCLES(3), .CNT_W(2)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .instr_d_i       (instr),
    .valid_d_i       (valid),
    .stall_e_i       (stall),
    .flush_e_i       (flush),
    .imm_src_d_o     (imm_src),
    .valid_e_o       (valid_e),
    .reg_write_e_o   (reg_write_e),
    .mem_write_e_o   (mem_write_e),
    .result_src_e_o  (result_src_e),
    .alu_src_a_e_o   (alu_src_a_e),
    .alu_src_b_e_o   (alu_src_b_e),
    .alu_ctrl_e_o    (alu_ctrl_e),
    .branch_e_o      (branch_e),
    .jump_e_o        (jump_e),
    .jalr_e_o        (jalr_e),
    .funct3_e_o      (funct3_e),
    .stall_fd_o      (stall_fd),
    .halted_o        (halted),
    .illegal_o       (illegal),
    .illegal_instr_o (illegal_instr)
  );

  logic [16:0] ex_act;
  assign ex_act = {valid_e, reg_write_e, mem_write_e, result_src_e, alu_src_a_e,
                   alu_src_b_e, alu_ctrl_e, branch_e, jump_e, jalr_e, funct3_e};

  typedef struct {
    logic [31:0] instr;
    logic        valid;
    logic        stall;
    logic        flush;
    logic [2:0]  imm;
    logic [16:0] ex;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] I_ADDI  = 32'h00500093;
  localparam logic [31:0] I_SW    = 32'h0020A423;
  localparam logic [31:0] I_LUI   = 32'h123452B7;
  localparam logic [31:0] I_JAL   = 32'h008000EF;
  localparam logic [31:0] I_ECALL = 32'h00000073;

  // {valid, reg_write, mem_write, result, src_a, src_b, alu, branch, jump, jalr, funct3}
  function automatic logic [16:0] mk(input logic v, input logic rw, input logic mw,
                                     input logic [1:0] res, input logic a, input logic b,
                                     input logic [3:0] alu, input logic br, input logic j,
                                     input logic jr, input logic [2:0] f3);
    return {v, rw, mw, res, a, b, alu, br, j, jr, f3};
  endfunction

  task automatic add(input logic [31:0] i, input logic v, input logic s, input logic f,
                     input logic [2:0] imm, input logic [16:0] ex);
    vec_t r;
    r.instr = i; r.valid = v; r.stall = s; r.flush = f; r.imm = imm; r.ex = ex;
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] i, input logic v, input logic s, input logic f);
    instr = i; valid = v; stall = s; flush = f;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  logic [16:0] addi_ex;
  logic [16:0] sys_ex;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    addi_ex = mk(1, 1, 0, 2'd0, 0, 1, 4'd0, 0, 0, 0, 3'd0);
    sys_ex  = mk(1, 0, 0, 2'd0, 0, 0, 4'd0, 0, 0, 0, 3'd0);

    add(I_ADDI,       1, 0, 0, 3'd0, addi_ex);
    add(I_SW,         1, 0, 0, 3'd1, mk(1, 0, 1, 2'd0, 0, 1, 4'd0, 0, 0, 0, 3'd2));
    add(32'h00208863, 1, 0, 0, 3'd2, mk(1, 0, 0, 2'd0, 0, 0, 4'd1, 1, 0, 0, 3'd0));
    add(32'h402081B3, 1, 0, 0, 3'd0, mk(1, 1, 0, 2'd0, 0, 0, 4'd1, 0, 0, 0, 3'd0));
    add(32'h0020F1B3, 1, 0, 0, 3'd0, mk(1, 1, 0, 2'd0, 0, 0, 4'd2, 0, 0, 0, 3'd7));
    add(32'hC0000093, 1, 0, 0, 3'd0, mk(1, 1, 0, 2'd0, 0, 1, 4'd0, 0, 0, 0, 3'd0));
    add(32'h4030D093, 1, 0, 0, 3'd0, mk(1, 1, 0, 2'd0, 0, 1, 4'd9, 0, 0, 0, 3'd5));
    add(32'h0030D093, 1, 0, 0, 3'd0, mk(1, 1, 0, 2'd0, 0, 1, 4'd8, 0, 0, 0, 3'd5));
    add(32'h00309093, 1, 0, 0, 3'd0, mk(1, 1, 0, 2'd0, 0, 1, 4'd7, 0, 0, 0, 3'd1));
    add(32'h0FF0C093, 1, 0, 0, 3'd0, mk(1, 1, 0, 2'd0, 0, 1, 4'd4, 0, 0, 0, 3'd4));
    add(32'h0020C463, 1, 0, 0, 3'd2, mk(1, 0, 0, 2'd0, 0, 0, 4'd5, 1, 0, 0, 3'd4));
    add(32'h0020D463, 1, 0, 0, 3'd2, mk(1, 0, 0, 2'd0, 0, 0, 4'd5, 1, 0, 0, 3'd5));
    add(32'h0020E463, 1, 0, 0, 3'd2, mk(1, 0, 0, 2'd0, 0, 0, 4'd6, 1, 0, 0, 3'd6));
    add(32'h00012083, 1, 0, 0, 3'd0, mk(1, 1, 0, 2'd1, 0, 1, 4'd0, 0, 0, 0, 3'd2));
    add(32'h000100E7, 1, 0, 0, 3'd0, mk(1, 1, 0, 2'd2, 0, 1, 4'd0, 0, 1, 1, 3'd0));
    add(32'h00001097, 1, 0, 0, 3'd4, mk(1, 1, 0, 2'd0, 1, 1, 4'd0, 0, 0, 0, 3'd1));
    add(32'h0FF0000F, 1, 0, 0, 3'd0, sys_ex);
    add(I_ADDI,       1, 0, 0, 3'd0, addi_ex);
    add(I_LUI,        1, 1, 0, 3'd4, addi_ex);
    add(I_LUI,        1, 1, 0, 3'd4, addi_ex);
    add(I_LUI,        1, 0, 0, 3'd4, mk(1, 1, 0, 2'd3, 0, 0, 4'd0, 0, 0, 0, 3'd5));
    add(I_JAL,        1, 0, 1, 3'd3, 17'd0);
    add(I_JAL,        1, 0, 0, 3'd3, mk(1, 1, 0, 2'd2, 0, 0, 4'd0, 0, 1, 0, 3'd0));
    add(I_SW,         0, 0, 0, 3'd1, 17'd0);
    add(I_ADDI,       1, 0, 0, 3'd0, addi_ex);
    add(I_SW,         1, 1, 1, 3'd1, 17'd0);

    // Reset state
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) cyc();
    chk("reset_ex", {15'd0, ex_act}, 32'd0);
    chk("reset_stall_fd", {31'd0, stall_fd}, 32'd0);
    chk("reset_halted", {31'd0, halted}, 32'd0);
    chk("reset_illegal", {31'd0, illegal}, 32'd0);
    chk("reset_illegal_instr", illegal_instr, 32'd0);
    rst = 1'b0;

    foreach (vecs[k]) begin
      drive(vecs[k].instr, vecs[k].valid, vecs[k].stall, vecs[k].flush);
      #1;
      chk($sformatf("vec%0d_imm_src", k), {29'd0, imm_src}, {29'd0, vecs[k].imm});
      cyc();
      chk($sformatf("vec%0d_ex", k), {15'd0, ex_act}, {15'd0, vecs[k].ex});
    end
    chk("table_no_illegal", {31'd0, illegal}, 32'd0);

    // Illegal capture: only on a real load cycle, first word wins
    do_reset();
    drive(32'h0000007F, 1'b1, 1'b0, 1'b1);
    cyc();
    chk("ill_flush_nocap", {31'd0, illegal}, 32'd0);
    drive(32'h0000007F, 1'b1, 1'b1, 1'b0);
    cyc();
    chk("ill_stall_nocap", {31'd0, illegal}, 32'd0);
    drive(32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    cyc();
    chk("ill1_valid_e", {31'd0, valid_e}, 32'd0);
    chk("ill1_flag", {31'd0, illegal}, 32'd1);
    chk("ill1_instr", illegal_instr, 32'hFFFFFFFF);
    drive(32'h0000007F, 1'b1, 1'b0, 1'b0);
    cyc();
    chk("ill2_valid_e", {31'd0, valid_e}, 32'd0);
    chk("ill2_instr_kept", illegal_instr, 32'hFFFFFFFF);
    drive(32'h00500090, 1'b1, 1'b0, 1'b0);
    cyc();
    chk("ill_lowbits_ex", {15'd0, ex_act}, 32'd0);
    drive(32'h34011073, 1'b1, 1'b0, 1'b0);
    cyc();
    chk("ill_csr_ex", {15'd0, ex_act}, 32'd0);
    drive(I_ADDI, 1'b1, 1'b0, 1'b0);
    cyc();
    chk("ill_pipe_continues", {15'd0, ex_act}, {15'd0, addi_ex});
    chk("ill_flag_sticky", {31'd0, illegal}, 32'd1);
    chk("ill_no_halt", {31'd0, stall_fd}, 32'd0);

    // ECALL blocked by stall/flush, then drain of exactly three cycles
    do_reset();
    drive(I_ECALL, 1'b1, 1'b1, 1'b0);
    #1;
    chk("ecall_imm_src", {29'd0, imm_src}, 32'd0);
    cyc();
    chk("ecall_stalled_run", {31'd0, stall_fd}, 32'd0);
    drive(I_ECALL, 1'b1, 1'b0, 1'b1);
    cyc();
    chk("ecall_flushed_run", {31'd0, stall_fd}, 32'd0);
    chk("ecall_flushed_ex", {15'd0, ex_act}, 32'd0);
    drive(I_ECALL, 1'b1, 1'b0, 1'b0);
    cyc();
    chk("drain_stall_fd", {31'd0, stall_fd}, 32'd1);
    chk("drain_halted0", {31'd0, halted}, 32'd0);
    chk("drain_ecall_ex", {15'd0, ex_act}, {15'd0, sys_ex});
    drive(I_ADDI, 1'b1, 1'b0, 1'b1);
    cyc();
    chk("drain2_halted", {31'd0, halted}, 32'd0);
    drive(I_ADDI, 1'b1, 1'b0, 1'b0);
    cyc();
    chk("drain3_halted", {31'd0, halted}, 32'd0);
    chk("drain3_bubble", {15'd0, ex_act}, 32'd0);
    cyc();
    chk("halted_set", {31'd0, halted}, 32'd1);
    chk("halted_stall_fd", {31'd0, stall_fd}, 32'd1);
    repeat (3) cyc();
    chk("halted_sticky", {31'd0, halted}, 32'd1);
    chk("halted_bubble", {15'd0, ex_act}, 32'd0);

    // Reset in the middle of a drain
    do_reset();
    drive(I_ECALL, 1'b1, 1'b0, 1'b0);
    cyc();
    chk("rdrain_stall_fd", {31'd0, stall_fd}, 32'd1);
    drive(I_ADDI, 1'b1, 1'b0, 1'b0);
    cyc();
    rst = 1'b1;
    cyc();
    chk("rdrain_run", {31'd0, stall_fd}, 32'd0);
    chk("rdrain_halted", {31'd0, halted}, 32'd0);
    chk("rdrain_ex", {15'd0, ex_act}, 32'd0);
    rst = 1'b0;
    cyc();
    chk("rdrain_reload", {15'd0, ex_act}, {15'd0, addi_ex});
    repeat (4) cyc();
    chk("rdrain_never_halts", {31'd0, halted}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
